// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Writer side of the FIR coefficient bank. A framed 2-bit symbol stream
//   (opened by `start`) fills a shadow register tap by tap, MSB symbol first.
//   A trailing parity symbol (XOR of all data symbols) is then checked. On a
//   match the shadow is committed to `coef_out` in one edge, so the FIR core
//   never sees a partial set.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   start      single-cycle pulse, opens/restarts a transfer (wins over din_valid)
//   din        2-bit data or parity symbol
//   din_valid  din is valid this cycle
//   coef_out   committed bank, tap k at [k*BW_coef +: BW_coef]
//   busy       high while loading or waiting for parity
//   done       one-cycle pulse on a successful commit
//   err        sticky parity-mismatch flag, cleared by start or reset
module fir_coef_loader #(
  parameter int N_TAPS  = 4,
  parameter int BW_coef = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  din,
  input  logic                        din_valid,
  output logic [N_TAPS*BW_coef-1:0]   coef_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int SPT = BW_coef / 2;           // symbols per tap
  localparam int S   = N_TAPS * SPT;          // data symbols per transfer
  localparam int CW  = $clog2(S + 1);
  localparam int W   = N_TAPS * BW_coef;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      par, par_n;
  logic [W-1:0]    shadow, shadow_n;
  logic [W-1:0]    coef_q, coef_n;
  logic            done_q, done_n;
  logic            err_q, err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      par    <= '0;
      shadow <= '0;
      coef_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      par    <= par_n;
      shadow <= shadow_n;
      coef_q <= coef_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    par_n    = par;
    shadow_n = shadow;
    coef_n   = coef_q;
    done_n   = 1'b0;
    err_n    = err_q;

    if (start) begin
      // Any symbol arriving with start is dropped; shadow bits are left stale
      // because every position is rewritten before the next commit.
      state_n = LOAD;
      cnt_n   = '0;
      par_n   = '0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (din_valid) begin
            // Symbol p belongs to tap p/SPT; within a tap the first symbol
            // lands in the most significant pair.
            for (int unsigned p = 0; p < S; p++) begin
              if (cnt == CW'(p))
                shadow_n[(p / SPT) * BW_coef + (SPT - 1 - (p % SPT)) * 2 +: 2] = din;
            end
            par_n = par ^ din;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(S - 1))
              state_n = CHECK;
          end
        end
        CHECK: begin
          if (din_valid) begin
            if (din == par) begin
              coef_n = shadow;
              done_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign coef_out = coef_q;
  assign busy     = (state == LOAD) || (state == CHECK);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  din = 2'b00;
  logic        din_valid = 1'b0;
  logic [15:0] coef_out;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Hand-derived symbol streams.
  // 0x4321: taps 1,2,3,4 -> 00 01 | 00 10 | 00 11 | 01 00, parity 01
  // 0xA5F0: taps 0,F,5,A -> 00 00 | 11 11 | 01 01 | 10 10, parity 00
  logic [1:0] s4321 [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
  logic [1:0] sa5f0 [8] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};

  fir_coef_loader #(.N_TAPS(4), .BW_coef(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .coef_out  (coef_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; din_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] d);
    din = d; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Data symbols then parity; returns right after the parity edge.
  task automatic send_frame(input logic [1:0] s [8], input logic [1:0] p);
    for (int i = 0; i < 8; i++) send(s[i]);
    send(p);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (coef_out !== 16'h0000) begin fails++; $display("FAIL reset_coef got %h want 0000", coef_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_nominal();
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL nom_busy_after_start got %b want 1", busy); end
    send_frame(s4321, 2'b01);
    tests++; if (coef_out !== 16'h4321) begin fails++; $display("FAIL nom_coef got %h want 4321", coef_out); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL nom_done got %b want 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nom_busy got %b want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL nom_err got %b want 0", err); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL nom_done_width got %b want 0", done); end
  endtask

  task automatic test_bad_parity();
    logic saw_done;
    do_reset();
    pulse_start();
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(s4321[i]);
      if (done) saw_done = 1'b1;
    end
    send(2'b10);
    if (done) saw_done = 1'b1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_err got %b want 1", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_busy got %b want 0", busy); end
    tests++; if (coef_out !== 16'h0000) begin fails++; $display("FAIL bad_coef got %h want 0000", coef_out); end
    tick(); tick();
    if (done) saw_done = 1'b1;
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL bad_done got %b want 0", saw_done); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_err_sticky got %b want 1", err); end
    pulse_start();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL bad_err_clear got %b want 0", err); end
  endtask

  task automatic test_gapped();
    int gaps [9] = '{2, 0, 3, 1, 0, 2, 3, 1, 0};
    logic early_done;
    do_reset();
    pulse_start();
    early_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        din = 2'b11;  // junk on an invalid cycle must be ignored
        tick();
        if (done) early_done = 1'b1;
      end
      if (i < 8) begin
        send(s4321[i]);
        if (done) early_done = 1'b1;
      end else begin
        send(2'b01);
      end
    end
    tests++; if (early_done !== 1'b0) begin fails++; $display("FAIL gap_early_done got %b want 0", early_done); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL gap_done got %b want 1", done); end
    tests++; if (coef_out !== 16'h4321) begin fails++; $display("FAIL gap_coef got %h want 4321", coef_out); end
  endtask

  task automatic test_abort();
    do_reset();
    pulse_start();
    send_frame(s4321, 2'b01);
    tick();
    pulse_start();
    for (int i = 0; i < 5; i++) send(sa5f0[i]);
    start = 1'b1; din = 2'b11; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy got %b want 1", busy); end
    tests++; if (coef_out !== 16'h4321) begin fails++; $display("FAIL abort_coef_hold got %h want 4321", coef_out); end
    for (int i = 0; i < 8; i++) send(sa5f0[i]);
    tests++; if (coef_out !== 16'h4321) begin fails++; $display("FAIL abort_coef_pre got %h want 4321", coef_out); end
    send(2'b00);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL abort_done got %b want 1", done); end
    tests++; if (coef_out !== 16'ha5f0) begin fails++; $display("FAIL abort_coef got %h want a5f0", coef_out); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL abort_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    logic stray;
    pulse_start();
    send_frame(s4321, 2'b01);
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) send(sa5f0[i]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (coef_out !== 16'h0000) begin fails++; $display("FAIL rmid_coef got %h want 0000", coef_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err got %b want 0", err); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rmid_done got %b want 0", done); end
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(s4321[i]);
      if (busy || done) stray = 1'b1;
    end
    send(2'b01);
    if (busy || done) stray = 1'b1;
    tests++; if (stray !== 1'b0) begin fails++; $display("FAIL rmid_nostart_activity got %b want 0", stray); end
    tests++; if (coef_out !== 16'h0000) begin fails++; $display("FAIL rmid_nostart_coef got %h want 0000", coef_out); end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    pulse_start();
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin din = s4321[i]; tick(); end
    din = 2'b01; tick();
    din_valid = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b want 1", done); end
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin din = sa5f0[i]; tick(); end
    din = 2'b00; tick();
    din_valid = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done2 got %b want 1", done); end
    tests++; if (cyc - c0 !== 10) begin fails++; $display("FAIL b2b_spacing got %0d want 10", cyc - c0); end
    tests++; if (coef_out !== 16'ha5f0) begin fails++; $display("FAIL b2b_coef got %h want a5f0", coef_out); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_parity();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
